motor_cmd_sequencer: RTL

//  Owns the duty inputs of NUM_MOTORS pwm_generator instances in the drone SoC.

---
 rtl/motor_cmd_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: owns the PWM duty words for NUM_MOTORS motors.
// Handles arm/disarm sequencing, per-frame slew limiting and a command-loss
// failsafe. Duties move only on frame_tick, so a PWM period never sees a
// mid-period duty change. The exceptions are disarm and reset, which zero
// the duties at once.
//
// Handshake: cmd_ready is high whenever rst_in is low. A command is taken on
// any clk_in edge where cmd_valid && cmd_ready; outside ARMED it is taken and
// dropped.
module motor_cmd_sequencer #(
   parameter int NUM_MOTORS     = 4,
   parameter int DUTY_W         = 8,
   parameter int DUTY_MAX       = 240,
   parameter int SLEW_STEP      = 16,
   parameter int ARM_FRAMES     = 50,
   parameter int TIMEOUT_FRAMES = 25,
   parameter int MOTOR_W        = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         frame_tick,
   input  logic                         arm_req,
   input  logic                         disarm_req,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [MOTOR_W-1:0]           cmd_motor,
   input  logic [DUTY_W-1:0]            cmd_duty,
   output logic [NUM_MOTORS*DUTY_W-1:0] duty_out,
   output logic                         armed,
   output logic                         failsafe,
   output logic [1:0]                   fsm_state
);

   localparam logic [1:0] S_DISARMED = 2'd0;
   localparam logic [1:0] S_ARMING   = 2'd1;
   localparam logic [1:0] S_ARMED    = 2'd2;
   localparam logic [1:0] S_FAILSAFE = 2'd3;

   localparam int FC_W = $clog2(ARM_FRAMES + 1);
   localparam int TC_W = $clog2(TIMEOUT_FRAMES + 1);

   localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(SLEW_STEP);
   localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(DUTY_MAX);
   localparam logic [FC_W-1:0]   ARM_LAST = FC_W'(ARM_FRAMES - 1);
   localparam logic [TC_W-1:0]   TO_LAST  = TC_W'(TIMEOUT_FRAMES - 1);

   logic [1:0]        state;
   logic [FC_W-1:0]   frame_cnt;
   logic [TC_W-1:0]   timeout_cnt;
   logic [DUTY_W-1:0] duty   [NUM_MOTORS];
   logic [DUTY_W-1:0] target [NUM_MOTORS];
   logic [DUTY_W-1:0] slewed [NUM_MOTORS];
   logic [DUTY_W:0]   cur, tgt, up, dn;
   logic [DUTY_W-1:0] clamped;
   logic              accept, motor_ok, all_zero;

   assign cmd_ready = ~rst_in;
   assign accept    = cmd_valid & cmd_ready;
   assign clamped   = (cmd_duty > MAX_D) ? MAX_D : cmd_duty;
   assign motor_ok  = (int'(cmd_motor) < NUM_MOTORS);
   assign armed     = (state == S_ARMED);
   assign failsafe  = (state == S_FAILSAFE);
   assign fsm_state = state;

   // One slew step toward each target. The math is one bit wider than the
   // duty so the step can never wrap past 0 or past full scale.
   always_comb begin
      cur      = '0;
      tgt      = '0;
      up       = '0;
      dn       = '0;
      all_zero = 1'b1;
      for (int m = 0; m < NUM_MOTORS; m++) begin
         cur       = {1'b0, duty[m]};
         tgt       = {1'b0, target[m]};
         up        = cur + STEP_X;
         dn        = cur - STEP_X;
         slewed[m] = duty[m];
         if (tgt > cur)
            slewed[m] = (up > tgt) ? target[m] : up[DUTY_W-1:0];
         else if (tgt < cur)
            slewed[m] = ((cur < STEP_X) || (dn < tgt)) ? target[m] : dn[DUTY_W-1:0];
         if (duty[m] != '0)
            all_zero = 1'b0;
      end
   end

   // Pack the per-motor duties onto the flat output bus.
   always_comb begin
      duty_out = '0;
      for (int m = 0; m < NUM_MOTORS; m++)
         duty_out[m*DUTY_W +: DUTY_W] = duty[m];
   end

   // Sequencer FSM, targets, duties and frame/timeout counters.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= S_DISARMED;
         frame_cnt   <= '0;
         timeout_cnt <= '0;
         for (int m = 0; m < NUM_MOTORS; m++) begin
            duty[m]   <= '0;
            target[m] <= '0;
         end
      end else if (disarm_req) begin
         // Disarm outranks everything else and skips the slew.
         state       <= S_DISARMED;
         frame_cnt   <= '0;
         timeout_cnt <= '0;
         for (int m = 0; m < NUM_MOTORS; m++) begin
            duty[m]   <= '0;
            target[m] <= '0;
         end
      end else begin
         case (state)
            S_DISARMED: begin
               for (int m = 0; m < NUM_MOTORS; m++) begin
                  duty[m]   <= '0;
                  target[m] <= '0;
               end
               if (arm_req) begin
                  state     <= S_ARMING;
                  frame_cnt <= '0;
               end
            end
            S_ARMING: begin
               if (frame_tick) begin
                  if (frame_cnt == ARM_LAST) begin
                     state       <= S_ARMED;
                     timeout_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            S_ARMED: begin
               // This slew uses the targets as they were before this cycle's accept.
               if (frame_tick)
                  for (int m = 0; m < NUM_MOTORS; m++)
                     duty[m] <= slewed[m];
               if (accept) begin
                  timeout_cnt <= '0;
                  if (motor_ok)
                     target[cmd_motor] <= clamped;
               end else if (frame_tick) begin
                  if (timeout_cnt == TO_LAST) begin
                     state <= S_FAILSAFE;
                     for (int m = 0; m < NUM_MOTORS; m++)
                        target[m] <= '0;
                  end else begin
                     timeout_cnt <= timeout_cnt + 1'b1;
                  end
               end
            end
            default: begin
               // FAILSAFE: ramp every motor down to zero, then disarm.
               for (int m = 0; m < NUM_MOTORS; m++)
                  target[m] <= '0;
               if (frame_tick)
                  for (int m = 0; m < NUM_MOTORS; m++)
                     duty[m] <= slewed[m];
               if (all_zero)
                  state <= S_DISARMED;
            end
         endcase
      end
   end

endmodule
